uart_avm_scheduler: RTL

- Sole owner of the RS232 UART Avalon-MM slave port (RX data 0x0, TX data 0x4, status 0x8).
- Exposes one byte-stream RX output (valid/ready) and one byte-stream TX input (valid/ready) to the image loader and result sender.
- Polls status, then grants the port round-robin between RX reads and TX writes.
- Lets the loader and sender share the UART without bus contention.

---
 rtl/uart_avm_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_avm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_avm_scheduler
// Description : Sole master of the UART Avalon-MM slave port. Polls the status
//               register, then grants the port round-robin between RX reads
//               (byte-stream output) and TX writes (byte-stream input).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_avm_scheduler #(
  parameter int RX_BASE     = 0,
  parameter int TX_BASE     = 4,
  parameter int STATUS_BASE = 8,
  parameter int TX_OK_BIT   = 6,
  parameter int RX_OK_BIT   = 7
) (
  input  logic        i_clk,
  input  logic        avm_rst_n,
  input  logic        i_enable,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count
);

  localparam logic [4:0] C_RX_ADDR     = 5'(RX_BASE);
  localparam logic [4:0] C_TX_ADDR     = 5'(TX_BASE);
  localparam logic [4:0] C_STATUS_ADDR = 5'(STATUS_BASE);

  typedef enum logic [2:0] {S_IDLE, S_STATUS, S_GAP, S_TX, S_RX} state_t;
  typedef enum logic [1:0] {G_NONE, G_RX, G_TX} grant_t;

  state_t     r_state;
  grant_t     r_pending;    // grant decided at status completion, issued after the gap
  logic       r_last_tx;    // 1: last serviced side was TX
  logic [7:0] r_tx_hold;    // byte accepted from the TX stream, awaiting its write

  logic   w_done;
  logic   w_status_done;
  logic   w_rx_elig;
  logic   w_tx_elig;
  grant_t w_grant;
  logic   w_unused;

  assign w_done        = (avm_read | avm_write) & ~avm_waitrequest;
  assign w_status_done = (r_state == S_STATUS) & w_done;
  assign w_rx_elig     = avm_readdata[RX_OK_BIT] & ~rx_valid;
  assign w_tx_elig     = avm_readdata[TX_OK_BIT] & tx_valid;
  assign w_unused      = ^avm_readdata[31:8];

  // Round-robin arbitration on the status word; disable suppresses any grant
  always_comb begin
    w_grant = G_NONE;
    if (i_enable) begin
      if (w_rx_elig && w_tx_elig) w_grant = r_last_tx ? G_RX : G_TX;
      else if (w_rx_elig)         w_grant = G_RX;
      else if (w_tx_elig)         w_grant = G_TX;
    end
  end

  // The TX byte is taken exactly in the status-completion cycle that grants TX
  assign tx_ready = w_status_done & (w_grant == G_TX);

  // Bus sequencer, RX output buffer and counters
  always_ff @(posedge i_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      r_state       <= S_IDLE;
      r_pending     <= G_NONE;
      r_last_tx     <= 1'b1;
      r_tx_hold     <= 8'h00;
      avm_address   <= C_STATUS_ADDR;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_count      <= 16'h0;
      tx_count      <= 16'h0;
    end else begin
      // Consumer handshake; an RX completion can never coincide with this
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        rx_count <= rx_count + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state     <= S_STATUS;
            avm_read    <= 1'b1;
            avm_address <= C_STATUS_ADDR;
          end
        end

        S_STATUS: begin
          if (w_done) begin
            avm_read  <= 1'b0;
            r_pending <= w_grant;
            if (w_grant == G_TX) r_tx_hold <= tx_data;
            r_state   <= i_enable ? S_GAP : S_IDLE;
          end
        end

        S_GAP: begin
          r_pending <= G_NONE;
          case (r_pending)
            G_RX: begin
              r_state     <= S_RX;
              avm_read    <= 1'b1;
              avm_address <= C_RX_ADDR;
            end
            G_TX: begin
              r_state       <= S_TX;
              avm_write     <= 1'b1;
              avm_address   <= C_TX_ADDR;
              avm_writedata <= {24'b0, r_tx_hold};
            end
            default: begin
              if (i_enable) begin
                r_state     <= S_STATUS;
                avm_read    <= 1'b1;
                avm_address <= C_STATUS_ADDR;
              end else begin
                r_state <= S_IDLE;
              end
            end
          endcase
        end

        S_TX: begin
          if (w_done) begin
            avm_write <= 1'b0;
            tx_count  <= tx_count + 16'd1;
            r_last_tx <= 1'b1;
            r_state   <= S_GAP;
          end
        end

        S_RX: begin
          if (w_done) begin
            avm_read  <= 1'b0;
            rx_data   <= avm_readdata[7:0];
            rx_valid  <= 1'b1;
            r_last_tx <= 1'b0;
            r_state   <= S_GAP;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
